// File: rtl/lvlpulse_pkg.sv
// Shared definitions for the level-to-pulse block: event direction
// encoding and the depth of the pending-event FIFO.
package lvlpulse_pkg;

  localparam logic EV_FALL    = 1'b0;
  localparam logic EV_RISE    = 1'b1;
  localparam int   FIFO_DEPTH = 2;

endpackage

// File: rtl/lvlpulse_qual.sv
// Level qualifier: q only follows l after l has differed from q for
// QUAL consecutive clock edges. ev/evdir flag the edge on which q changes.
module lvlqual
  import lvlpulse_pkg::*;
#(
  parameter int QUAL = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic l,
  output logic q,
  output logic ev,
  output logic evdir
);

  localparam logic [7:0] QLAST = 8'(QUAL - 1);

  logic [7:0] qc;

  // ev is combinational so the emitter can pulse on the same edge as q moves.
  always_comb begin
    ev    = (l != q) && (qc == QLAST);
    evdir = l ? EV_RISE : EV_FALL;
  end

  // Persistence counter and qualified output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= 1'b0;
      qc <= 8'd0;
    end else if (l == q) begin
      qc <= 8'd0;
    end else if (ev) begin
      q  <= l;
      qc <= 8'd0;
    end else begin
      qc <= qc + 8'd1;
    end
  end

endmodule

// File: rtl/lvlpulse.sv
// Level-to-pulse converter: qualifies a raw level, turns each accepted
// change into a rise/fall pulse, and rate-limits pulses to one per GAP
// ticks using a 2-entry FIFO of pending directions.
module lvlpulse
  import lvlpulse_pkg::*;
#(
  parameter int QUAL = 3,
  parameter int GAP  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       l,
  output logic       q,
  output logic       pr,
  output logic       pf,
  output logic [1:0] pend,
  output logic       ovf
);

  localparam logic [7:0] GLAST = 8'(GAP - 1);
  localparam logic [1:0] FULL  = 2'(FIFO_DEPTH);

  logic       ev;
  logic       evdir;
  logic [1:0] fifo_mem;
  logic       rp;
  logic       wp;
  logic [7:0] gc;

  logic gap_ok, empty, full, pop, bypass, push, drop, push_ok, emit, emit_dir;

  lvlqual #(.QUAL(QUAL)) u_qual (
    .clk   (clk),
    .reset (reset),
    .l     (l),
    .q     (q),
    .ev    (ev),
    .evdir (evdir)
  );

  // Emit/push/drop decisions for the current edge.
  always_comb begin
    gap_ok   = (gc == 8'd0);
    empty    = (pend == 2'd0);
    full     = (pend == FULL);
    pop      = gap_ok && !empty;
    bypass   = ev && empty && gap_ok;
    push     = ev && !bypass;
    drop     = push && full && !pop;
    push_ok  = push && !drop;
    emit     = pop || bypass;
    emit_dir = pop ? fifo_mem[rp] : evdir;
  end

  // Pulse outputs, gap counter, FIFO storage/pointers and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pr       <= 1'b0;
      pf       <= 1'b0;
      gc       <= 8'd0;
      fifo_mem <= 2'b00;
      rp       <= 1'b0;
      wp       <= 1'b0;
      pend     <= 2'd0;
      ovf      <= 1'b0;
    end else begin
      pr <= emit && (emit_dir == EV_RISE);
      pf <= emit && (emit_dir == EV_FALL);
      if (emit)
        gc <= GLAST;
      else if (gc != 8'd0)
        gc <= gc - 8'd1;
      if (push_ok) begin
        fifo_mem[wp] <= evdir;
        wp           <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      unique case ({push_ok, pop})
        2'b10:   pend <= pend + 2'd1;
        2'b01:   pend <= pend - 2'd1;
        default: pend <= pend;
      endcase
      if (drop)
        ovf <= 1'b1;
    end
  end

endmodule

// File: doc/lvlpulse.md
LVLPULSE -- requirements
Module: lvlpulse

Interface
REQ-001 Parameter QUAL, default 3: consecutive clock ticks a level change must persist before it is accepted; legal range 1..255.
REQ-002 Parameter GAP, default 5: minimum ticks between the starts of consecutive output pulses; legal range 1..255.
REQ-003 Port clk, input, 1: single clock, 10 ns tick; only clock in the block.
REQ-004 Port reset, input, 1: synchronous, active-high.
REQ-005 Port l, input, 1: raw level input, synchronous to clk.
REQ-006 Port q, output, 1: qualified copy of l.
REQ-007 Port pr, output, 1: one-tick pulse for each accepted rising change of q.
REQ-008 Port pf, output, 1: one-tick pulse for each accepted falling change of q.
REQ-009 Port pend, output, 2: number of queued, not-yet-emitted events (0..2).
REQ-010 Port ovf, output, 1: sticky flag, set when an event is dropped.

Function
REQ-011 Qualifier: counter qc is cleared on every edge that samples l == q, and increments on every edge that samples l != q.
REQ-012 q SHALL take the value of l on the edge where l != q is sampled and qc == QUAL-1; qc clears on that same edge.
REQ-013 Latency: with QUAL=N, l changes before edge k and stays stable, so q changes after edge k+N-1.
REQ-014 With QUAL=1, q follows l one tick late.
REQ-015 Every q change creates one event: rise if the new q is 1, fall if the new q is 0.
REQ-016 Emitter: gap counter gc decrements each tick while it is nonzero.
REQ-017 An emit is allowed only when gc == 0.
REQ-018 An emit asserts pr or pf for exactly one tick and loads gc = GAP-1.
REQ-019 Bypass: if an event occurs while the FIFO is empty and gc == 0, its pulse is asserted on the same edge as the q change, so pr/pf rise together with the new q.
REQ-020 Otherwise the event is pushed into a 2-entry FIFO of 1-bit directions.
REQ-021 The FIFO head is popped and emitted on the first edge where gc == 0.
REQ-022 Events are emitted in arrival order; pr and pf are never high in the same tick.
REQ-023 Pulse spacing: consecutive pulses start at least GAP ticks apart; GAP=1 allows back-to-back pulses.
REQ-024 Full FIFO with a new event and no pop on that edge: the event is dropped and ovf is set; ovf holds until reset.
REQ-025 Full FIFO with a pop and a push on the same edge: the push is accepted and ovf is unchanged.
REQ-026 pend SHALL equal the FIFO occupancy after each edge.
REQ-027 If QUAL >= GAP the FIFO cannot fill; this is a normal case, not an error.

Reset
REQ-028 While reset is high at an edge, these are 0 after that edge: q, pr, pf, pend, ovf, qc, gc, and FIFO contents/pointers.
REQ-029 Reset mid-operation discards all queued events; no pulse follows reset unless it comes from a fresh event.
REQ-030 If l=1 when reset is released, the rise qualifies after QUAL ticks as normal.

Structure
REQ-031 Shared package holds the event encoding (EV_FALL=0, EV_RISE=1) and the FIFO depth constant (2).
REQ-032 The qualifier is one sub-module, lvlqual (clk, reset, l -> q, ev, evdir); lvlpulse contains the FIFO and the emitter.

Verification
REQ-033 Reset: hold reset 3 ticks with l=1 -> q, pr, pf, pend, ovf all 0; after release, q=1 and pr=1 after the 3rd edge (QUAL=3).
REQ-034 Qualification (QUAL=3, GAP=5): l high before edge 0 and held -> q=1 and pr=1 after edge 2; pr=0 after edge 3.
REQ-035 Glitch (QUAL=3): l high for 2 edges, then low -> q stays 0, no pr/pf, qc back at 0.
REQ-036 Overflow (QUAL=1, GAP=5): l = 1,0,1,0 before edges 0..3 -> pr after edge 0, pf after edge 5, pr after edge 10; pend peaks at 2; ovf=1 after edge 3; no 4th pulse.
REQ-037 Simultaneous pop/push (QUAL=1, GAP=5, FIFO full, new event on the edge where gc reaches 0) -> pulse emitted, event accepted, pend stays 2, ovf=0.
REQ-038 Reset mid-operation: assert reset with pend=2 -> all outputs 0 after that edge; no pulses for 20 ticks with l held at 0.
